// File: rtl/crc_check_pkg.sv
// Shared types and bit-serial CRC helpers for the receive-side frame checker.
package crc_check_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        RUN    = 2'd2,
        RESULT = 2'd3
    } state_t;

    // Operands are carried in 64 bits so one function serves every CRC width.
    function automatic logic [63:0] crc_byte_step(input logic [63:0] crc,
                                                  input logic [7:0]  data,
                                                  input logic [63:0] poly,
                                                  input int          width);
        logic [63:0] c;
        logic        fb;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            fb = c[6'(width - 1)] ^ data[3'(7 - i)];
            c  = c << 1;
            if (fb) begin
                c = c ^ poly;
            end else begin
                c = c;
            end
        end
        for (int j = 0; j < 64; j++) begin
            if (j >= width) begin
                c[6'(j)] = 1'b0;
            end else begin
                c[6'(j)] = c[6'(j)];
            end
        end
        return c;
    endfunction

    function automatic logic [7:0] bitrev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[3'(i)] = b[3'(7 - i)];
        end
        return r;
    endfunction

    function automatic logic [63:0] bitrevN(input logic [63:0] x, input int width);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 64; i++) begin
            if (i < width) begin
                r[6'(i)] = x[6'(width - 1 - i)];
            end else begin
                r[6'(i)] = 1'b0;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/crc_byte_engine.sv
// One-byte CRC update; kept separate so a parallel equation set can replace the loop.
module crc_byte_engine
    import crc_check_pkg::*;
#(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] POLY       = WIDTH'(32'h04C11DB7),
    parameter bit               REFLECT_IN = 1'b1
) (
    input  logic [WIDTH-1:0] crc_in,
    input  logic [7:0]       data,
    output logic [WIDTH-1:0] crc_out
);

    logic [7:0] byte_s;

    // Optional input reflection, then fold the byte in MSB-first.
    always_comb begin
        if (REFLECT_IN) begin
            byte_s = bitrev8(data);
        end else begin
            byte_s = data;
        end
        crc_out = WIDTH'(crc_byte_step(64'(crc_in), byte_s, 64'(POLY), WIDTH));
    end

endmodule

// File: rtl/crc_frame_checker.sv
// Receive-side CRC checker: the last N bytes of each frame are held back in a delay
// line so only the payload reaches the CRC engine; the held bytes form the received field.
module crc_frame_checker
    import crc_check_pkg::*;
#(
    parameter int               WIDTH         = 32,
    parameter logic [WIDTH-1:0] POLY          = WIDTH'(32'h04C11DB7),
    parameter bit               REFLECT_IN    = 1'b1,
    parameter logic [WIDTH-1:0] XOR_IN        = {WIDTH{1'b1}},
    parameter bit               REFLECT_OUT   = 1'b1,
    parameter logic [WIDTH-1:0] XOR_OUT       = {WIDTH{1'b1}},
    parameter bit               CRC_LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       din,
    input  logic             din_valid,
    input  logic             din_last,
    output logic             din_ready,
    output logic             frame_done,
    output logic             crc_ok,
    output logic             crc_err,
    output logic             len_err,
    output logic [WIDTH-1:0] crc_calc_out,
    output logic [WIDTH-1:0] crc_rx
);

    localparam int             N   = WIDTH / 8;
    localparam int             CW  = $clog2(N + 1);
    localparam logic [CW-1:0]  N_C = CW'(N);

    state_t           state_r, state_next_s;
    logic [CW-1:0]    cnt_r, cnt_next_s;
    logic [WIDTH-1:0] dl_r, dl_next_s;
    logic [WIDTH-1:0] crc_r, crc_next_s, crc_step_s;
    logic [WIDTH-1:0] fin_s, rx_s, tmp_s;
    logic             din_ready_r;
    logic             accept_s, done_s, short_s;

    assign accept_s  = din_valid & din_ready_r;
    assign done_s    = accept_s & din_last;
    assign short_s   = (cnt_next_s != N_C);
    assign din_ready = din_ready_r;

    crc_byte_engine #(
        .WIDTH      (WIDTH),
        .POLY       (POLY),
        .REFLECT_IN (REFLECT_IN)
    ) u_engine (
        .crc_in  (crc_r),
        .data    (dl_r[7:0]),
        .crc_out (crc_step_s)
    );

    // Next-state logic for the FSM.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE, FILL: begin
                if (accept_s) begin
                    if (din_last) begin
                        state_next_s = RESULT;
                    end else if (cnt_next_s == N_C) begin
                        state_next_s = RUN;
                    end else begin
                        state_next_s = FILL;
                    end
                end else begin
                    state_next_s = state_r;
                end
            end
            RUN: begin
                if (done_s) begin
                    state_next_s = RESULT;
                end else begin
                    state_next_s = RUN;
                end
            end
            RESULT:  state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Delay line, byte counter and CRC register updates; cleared on the way back to IDLE.
    always_comb begin
        dl_next_s  = dl_r;
        cnt_next_s = cnt_r;
        crc_next_s = crc_r;
        if (state_r == RESULT) begin
            dl_next_s  = '0;
            cnt_next_s = '0;
            crc_next_s = XOR_IN;
        end else if (accept_s) begin
            if (state_r == RUN) begin
                dl_next_s              = dl_r >> 4'd8;
                dl_next_s[WIDTH-1 -: 8] = din;
                crc_next_s             = crc_step_s;
            end else begin
                dl_next_s  = dl_r | (WIDTH'(din) << {cnt_r, 3'b000});
                cnt_next_s = cnt_r + CW'(1);
            end
        end else begin
            dl_next_s = dl_r;
        end
    end

    // Final CRC and received-field assembly, both taken after the current beat lands.
    always_comb begin
        tmp_s = dl_next_s;
        rx_s  = '0;
        if (REFLECT_OUT) begin
            fin_s = WIDTH'(bitrevN(64'(crc_next_s), WIDTH)) ^ XOR_OUT;
        end else begin
            fin_s = crc_next_s ^ XOR_OUT;
        end
        if (CRC_LSB_FIRST) begin
            rx_s = dl_next_s;
        end else begin
            for (int i = 0; i < N; i++) begin
                rx_s  = (rx_s << 4'd8) | WIDTH'(tmp_s[7:0]);
                tmp_s = tmp_s >> 4'd8;
            end
        end
    end

    // Control and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            cnt_r       <= '0;
            dl_r        <= '0;
            crc_r       <= XOR_IN;
            din_ready_r <= 1'b1;
        end else begin
            state_r     <= state_next_s;
            cnt_r       <= cnt_next_s;
            dl_r        <= dl_next_s;
            crc_r       <= crc_next_s;
            din_ready_r <= (state_next_s != RESULT);
        end
    end

    // Result registers: flags pulse with frame_done, vectors hold until the next frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_done   <= 1'b0;
            crc_ok       <= 1'b0;
            crc_err      <= 1'b0;
            len_err      <= 1'b0;
            crc_calc_out <= '0;
            crc_rx       <= '0;
        end else if (done_s) begin
            frame_done   <= 1'b1;
            crc_ok       <= !short_s && (fin_s == rx_s);
            crc_err      <= short_s || (fin_s != rx_s);
            len_err      <= short_s;
            crc_calc_out <= fin_s;
            crc_rx       <= rx_s;
        end else begin
            frame_done   <= 1'b0;
            crc_ok       <= 1'b0;
            crc_err      <= 1'b0;
            len_err      <= 1'b0;
        end
    end

endmodule
